jy_irq_unit: RTL and testbench
==============================

# jy_irq_unit

Parametrised prescaler/counter IRQ engine for the J.Y.-family mappers (90/209/211 and successors). It provides selectable count sources and a generic prescaler mask width, plus counter width, XOR-keyed loads, up/down counting and an auto-reload mode. The enclosing mapper instantiates it, decodes the $C00x register window into `reg_we`/`reg_addr`, and routes `irq` to the cartridge IRQ line.

## Interface
Parameters:
- `PRE_W`, 8: prescaler width; supported range 3..8.
- `CNT_W`, 8: counter width; supported range 8..16.
- `A12_FILT`, 3: consecutive low `clk` samples of synchronised A12 required before a rise counts.

Ports:
- `clk`  in  1  system clock; everything is sampled on its rising edge.
- `map_rst_n`  in  1  synchronous, active-low reset.
- `cpu_tick`  in  1  one-`clk` strobe per CPU (M2) cycle.
- `ppu_a12`  in  1  raw PPU A12, asynchronous; synchronised internally through 2 flops.
- `ppu_rd`  in  1  one-`clk` strobe per PPU read.
- `cpu_wr`  in  1  one-`clk` strobe per CPU write, any address.
- `reg_we`  in  1  register write strobe, one `clk`.
- `reg_addr`  in  3  register index.
- `reg_wdat`  in  8  write data.
- `reg_rdat`  out  8  read data, registered.
- `irq`  out  1  pending IRQ, active-high.

## Operation
Registers, indexed by `reg_addr`:
- **0**: `wdat[0]`=1 enables. `wdat[0]`=0 disables and clears pending.
- **1**: mode register.
  - `[1:0]` src: 0 = `cpu_tick`, 1 = filtered A12 rise, 2 = `ppu_rd`, 3 = `cpu_wr`.
  - `[2]` short prescaler: only bits `[2:0]` are active.
  - `[3]` auto-reload.
  - `[7:6]` dir: 01 = up, 10 = down, 00/11 = hold.
- **2**: disable and clear pending.
- **3**: enable.
- **4**: prescaler ← `wdat ^ key`, truncated to `PRE_W`.
- **5**: counter`[7:0]` ← `wdat ^ key`; the reload latch low byte takes the same value.
- **6**: key ← `wdat`.
- **7**: counter`[CNT_W-1:8]` ← `wdat ^ key`, also copied to the reload latch. Ignored when `CNT_W`=8.

Reads return mode, prescaler, counter low, key, and counter high (zero-padded) for indices 1, 4, 5, 6 and 7. Every other index returns `{7'b0, pending}`.

Counting:
- An event is the selected source strobe in a `clk` where `reg_we`=0. A write cycle always swallows a coincident event.
- On each event the prescaler increments within its active mask (`PRE_W` bits, or 3 bits in short mode).
- Carry: the active prescaler bits are all ones before the increment. The counter steps in the same `clk` as the carry, according to dir.
- Terminal step: down from 0, or up from all-ones.
  - Without auto-reload, the counter wraps.
  - With auto-reload, the counter loads the reload latch.
  - If enabled, pending is set.
- Hold direction: the prescaler still runs; the counter and pending are unchanged.
- A12 filter: a 0→1 on synchronised A12 counts only if the preceding `A12_FILT` samples were all 0.

## Timing
- Reset (`map_rst_n`=0 at a `clk` edge) clears:
  - enable, pending, prescaler, counter, reload latch, key and mode;
  - `irq`=0, `reg_rdat`=0;
  - the A12 sync/filter history, to all zeros.
- Reset mid-count discards all state; nothing survives.
- The register write takes effect at the edge where `reg_we`=1. `reg_rdat` reflects the new value one `clk` later.
- Event to `irq`: an event at edge N that sets pending drives `irq`=1 after edge N.
- A12 latency: 2 sync cycles plus 1 edge-detect cycle, so a raw rise counts 3 `clk` later.
- Pending stays set until a reg-0 (`wdat[0]`=0) or reg-2 write, or reset. Further terminal steps while pending do nothing extra.
- A reg-3 enable does not clear pending.

## Structure
- A shared package `jy_irq_pkg` holds:
  - the source encoding (`SRC_CPU`, `SRC_A12`, `SRC_PPURD`, `SRC_CPUWR`);
  - the dir encoding;
  - the register index constants 0..7.
- The A12 synchroniser/filter is one sub-module, `jy_a12_edge`: parameter `A12_FILT`, inputs `clk`/`map_rst_n`/`ppu_a12`, output a one-`clk` `rise` strobe.

## Test plan
- **Basic down-count.** Key=0; write reg5=2 and reg1=0x80 (down, CPU source, 8-bit prescaler); enable; pulse 256×3 `cpu_tick`. Required: counter goes 2→1→0→0xFF, and `irq`=1 exactly one `clk` after the 768th tick.
- **XOR load, short prescaler, auto-reload.** Key=0x5A; write reg5=0x5F, so counter=0x05. Set mode 0x4C (up, short, auto-reload). Force counter to 0xFF via reg5=0xA5. Required:
  - a carry every 8 events;
  - at the terminal step the counter reloads to 0xFF, the last latch value, not 0x00;
  - `irq` sets.
- **A12 source.** Select A12 source, `A12_FILT`=3. Apply a rise after 2 low cycles (must not count), then a rise after 5 low cycles (must count). Check the prescaler each time.
- **Write swallows event.** Assert `reg_we` (reg6) together with `cpu_tick`. Required: prescaler unchanged. Also check a reg2 write while pending: `irq`→0 next `clk`.
- **Reset mid-operation.** Reset with pending=1 and counter=0x37. Required: all reads return 0 and `irq`=0. After reset the prescaler restarts from 0.
- **CNT_W=16.** Write reg7=0x01 and reg5=0x00, counting down. Required: 0x100 steps before `irq`; the high byte reads back 0x01 at reg7 before counting starts.

Source files
------------

// File: rtl/jy_irq_pkg.sv
// Shared encodings for the J.Y.-family IRQ engine: count sources, count direction,
// register indices and the packed mode register layout.
package jy_irq_pkg;

    typedef enum logic [1:0] {
        SRC_CPU   = 2'd0,
        SRC_A12   = 2'd1,
        SRC_PPURD = 2'd2,
        SRC_CPUWR = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        DIR_HOLD  = 2'b00,
        DIR_UP    = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_HOLD2 = 2'b11
    } dir_e;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_MODE   = 3'd1;
    localparam logic [2:0] REG_DIS    = 3'd2;
    localparam logic [2:0] REG_ENA    = 3'd3;
    localparam logic [2:0] REG_PRE    = 3'd4;
    localparam logic [2:0] REG_CNT_LO = 3'd5;
    localparam logic [2:0] REG_KEY    = 3'd6;
    localparam logic [2:0] REG_CNT_HI = 3'd7;

    typedef struct packed {
        dir_e       dir;        // [7:6]
        logic [1:0] rsvd;       // [5:4], stored and read back only
        logic       reload;     // [3]
        logic       short_pre;  // [2]
        src_e       src;        // [1:0]
    } mode_t;

endpackage

// File: rtl/jy_a12_edge.sv
// PPU A12 synchroniser and low-time filter: 2-flop sync, then a rise is reported only
// after A12_FILT consecutive low samples. Latency 3 clk from raw rise to counted event.
module jy_a12_edge #(
    parameter int A12_FILT = 3
) (
    input  logic clk,
    input  logic map_rst_n,
    input  logic ppu_a12,
    output logic rise
);

    logic [1:0]          sync;
    logic [A12_FILT-1:0] hist;

    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            sync <= '0;
            hist <= '0;
        end else begin
            sync <= {sync[0], ppu_a12};
            hist <= (hist << 1) | A12_FILT'(sync[1]);
        end
    end

    // hist holds the A12_FILT samples preceding the current synchronised value
    assign rise = sync[1] & ~|hist;

endmodule

// File: rtl/jy_irq_unit.sv
// Prescaler/counter IRQ engine with selectable source, XOR-keyed loads, up/down count
// and auto-reload. irq follows the pending flop; a register write swallows a same-cycle event.
module jy_irq_unit
    import jy_irq_pkg::*;
#(
    parameter int PRE_W    = 8,
    parameter int CNT_W    = 8,
    parameter int A12_FILT = 3
) (
    input  logic       clk,
    input  logic       map_rst_n,
    input  logic       cpu_tick,
    input  logic       ppu_a12,
    input  logic       ppu_rd,
    input  logic       cpu_wr,
    input  logic       reg_we,
    input  logic [2:0] reg_addr,
    input  logic [7:0] reg_wdat,
    output logic [7:0] reg_rdat,
    output logic       irq
);

    localparam logic [CNT_W-1:0] LO_MASK = CNT_W'(8'hFF);

    logic             en;
    logic             pend;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rld;
    logic [7:0]       key;
    mode_t            mode;

    logic             a12_rise;
    logic             src_hit;
    logic             evt;
    logic             carry;
    logic             term;
    logic [PRE_W-1:0] pre_mask;
    logic [PRE_W-1:0] pre_inc;
    logic [CNT_W-1:0] cnt_step;
    logic [7:0]       wd_x;
    logic [CNT_W-1:0] cnt_lo_wr, cnt_hi_wr, rld_lo_wr, rld_hi_wr;
    logic [7:0]       rd_mux;

    jy_a12_edge #(.A12_FILT(A12_FILT)) u_a12 (
        .clk       (clk),
        .map_rst_n (map_rst_n),
        .ppu_a12   (ppu_a12),
        .rise      (a12_rise)
    );

    always_comb begin
        src_hit = 1'b0;
        case (mode.src)
            SRC_CPU:   src_hit = cpu_tick;
            SRC_A12:   src_hit = a12_rise;
            SRC_PPURD: src_hit = ppu_rd;
            SRC_CPUWR: src_hit = cpu_wr;
            default:   src_hit = 1'b0;
        endcase
    end

    assign evt      = src_hit & ~reg_we;
    assign pre_mask = mode.short_pre ? PRE_W'(3'b111) : '1;
    // Bits above the short mask keep their value while short mode is active
    assign pre_inc  = (pre & ~pre_mask) | ((pre + PRE_W'(1)) & pre_mask);
    assign carry    = evt && ((pre & pre_mask) == pre_mask);

    always_comb begin
        term     = 1'b0;
        cnt_step = cnt;
        case (mode.dir)
            DIR_UP: begin
                term     = &cnt;
                cnt_step = cnt + CNT_W'(1);
            end
            DIR_DOWN: begin
                term     = (cnt == '0);
                cnt_step = cnt - CNT_W'(1);
            end
            default: ;
        endcase
        if (term && mode.reload)
            cnt_step = rld;
    end

    assign wd_x      = reg_wdat ^ key;
    // With CNT_W=8 the high-byte casts truncate to zero, leaving the counter untouched
    assign cnt_lo_wr = (cnt & ~LO_MASK) | CNT_W'(wd_x);
    assign rld_lo_wr = (rld & ~LO_MASK) | CNT_W'(wd_x);
    assign cnt_hi_wr = (cnt & LO_MASK) | CNT_W'({wd_x, 8'h00});
    assign rld_hi_wr = (rld & LO_MASK) | CNT_W'({wd_x, 8'h00});

    always_comb begin
        rd_mux = {7'b0, pend};
        case (reg_addr)
            REG_MODE:   rd_mux = mode;
            REG_PRE:    rd_mux = 8'(pre);
            REG_CNT_LO: rd_mux = cnt[7:0];
            REG_KEY:    rd_mux = key;
            REG_CNT_HI: rd_mux = 8'({8'h00, cnt} >> 8);
            default:    rd_mux = {7'b0, pend};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            en       <= 1'b0;
            pend     <= 1'b0;
            pre      <= '0;
            cnt      <= '0;
            rld      <= '0;
            key      <= '0;
            mode     <= '0;
            reg_rdat <= '0;
        end else begin
            reg_rdat <= rd_mux;
            if (evt) begin
                pre <= pre_inc;
                if (carry) begin
                    cnt <= cnt_step;
                    if (term && en)
                        pend <= 1'b1;
                end
            end
            if (reg_we) begin
                case (reg_addr)
                    REG_CTRL: begin
                        en <= reg_wdat[0];
                        if (!reg_wdat[0])
                            pend <= 1'b0;
                    end
                    REG_MODE:   mode <= mode_t'(reg_wdat);
                    REG_DIS: begin
                        en   <= 1'b0;
                        pend <= 1'b0;
                    end
                    REG_ENA:    en  <= 1'b1;
                    REG_PRE:    pre <= PRE_W'(wd_x);
                    REG_CNT_LO: begin
                        cnt <= cnt_lo_wr;
                        rld <= rld_lo_wr;
                    end
                    REG_KEY:    key <= reg_wdat;
                    REG_CNT_HI: begin
                        cnt <= cnt_hi_wr;
                        rld <= rld_hi_wr;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign irq = pend;

endmodule

// File: tb/tb_jy_irq_unit.sv
// Directed bench for jy_irq_unit: an 8-bit-counter instance and a 16-bit-counter
// instance share all stimulus; expected values are hand-computed constants.
module tb_jy_irq_unit;

    logic       clk;
    logic       map_rst_n;
    logic       cpu_tick;
    logic       ppu_a12;
    logic       ppu_rd;
    logic       cpu_wr;
    logic       reg_we;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdat;
    logic [7:0] rdat, rdat16;
    logic       irq, irq16;

    int checks = 0;
    int errors = 0;

    jy_irq_unit #(.PRE_W(8), .CNT_W(8), .A12_FILT(3)) dut (
        .clk(clk), .map_rst_n(map_rst_n), .cpu_tick(cpu_tick), .ppu_a12(ppu_a12),
        .ppu_rd(ppu_rd), .cpu_wr(cpu_wr), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdat(reg_wdat), .reg_rdat(rdat), .irq(irq)
    );

    jy_irq_unit #(.PRE_W(8), .CNT_W(16), .A12_FILT(3)) dut16 (
        .clk(clk), .map_rst_n(map_rst_n), .cpu_tick(cpu_tick), .ppu_a12(ppu_a12),
        .ppu_rd(ppu_rd), .cpu_wr(cpu_wr), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdat(reg_wdat), .reg_rdat(rdat16), .irq(irq16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_we   = 1'b1;
        reg_addr = a;
        reg_wdat = d;
        cyc(1);
        reg_we   = 1'b0;
    endtask

    // rdat then holds the addressed register as it stood before this edge
    task automatic rd(input logic [2:0] a);
        reg_addr = a;
        cyc(1);
    endtask

    task automatic tick(input int n);
        cpu_tick = 1'b1;
        cyc(n);
        cpu_tick = 1'b0;
    endtask

    initial begin
        map_rst_n = 1'b0;
        cpu_tick  = 1'b0;
        ppu_a12   = 1'b0;
        ppu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = 3'd0;
        reg_wdat  = 8'd0;
        cyc(2);
        chk("rst_irq", irq, 0);
        chk("rst_rdat", rdat, 0);
        map_rst_n = 1'b1;

        // Basic down-count, 8-bit prescaler, CPU source
        wr(6, 8'h00);
        wr(5, 8'h02);
        wr(1, 8'h80);
        wr(3, 8'h01);
        rd(5); chk("dn_cnt_init", rdat, 8'h02);
        rd(1); chk("dn_mode", rdat, 8'h80);
        tick(255);
        rd(4); chk("dn_pre_ff", rdat, 8'hFF);
        rd(5); chk("dn_cnt_before_carry", rdat, 8'h02);
        tick(1);
        rd(5); chk("dn_cnt_1", rdat, 8'h01);
        rd(4); chk("dn_pre_wrap", rdat, 8'h00);
        tick(256);
        rd(5); chk("dn_cnt_0", rdat, 8'h00);
        tick(255);
        chk("dn_irq_767", irq, 0);
        tick(1);
        chk("dn_irq_768", irq, 1);
        rd(5); chk("dn_cnt_wrap", rdat, 8'hFF);
        rd(0); chk("dn_pend_read", rdat, 8'h01);

        // Register write swallows a coincident event
        reg_we = 1'b1; reg_addr = 3'd6; reg_wdat = 8'h00; cpu_tick = 1'b1;
        cyc(1);
        reg_we = 1'b0; cpu_tick = 1'b0;
        rd(4); chk("swallow_pre", rdat, 8'h00);
        wr(2, 8'h00);
        chk("reg2_clears_irq", irq, 0);
        rd(0); chk("reg2_pend_read", rdat, 8'h00);

        // XOR-keyed loads, short prescaler, auto-reload, up count
        wr(6, 8'h5A);
        wr(5, 8'h5F);
        rd(5); chk("xor_cnt", rdat, 8'h05);
        rd(6); chk("key_read", rdat, 8'h5A);
        wr(1, 8'h4C);
        wr(5, 8'hA5);
        rd(5); chk("xor_cnt_ff", rdat, 8'hFF);
        wr(4, 8'h5A);
        wr(3, 8'h00);
        tick(7);
        rd(4); chk("short_pre_7", rdat, 8'h07);
        rd(5); chk("short_no_carry", rdat, 8'hFF);
        chk("short_irq_0", irq, 0);
        tick(1);
        chk("reload_irq", irq, 1);
        rd(5); chk("reload_cnt", rdat, 8'hFF);
        rd(4); chk("short_pre_wrap", rdat, 8'h00);
        wr(3, 8'h00);
        chk("ena_keeps_pend", irq, 1);
        wr(5, 8'hA7);
        tick(8);
        rd(5); chk("up_fe", rdat, 8'hFE);
        tick(8);
        rd(5); chk("up_ff", rdat, 8'hFF);
        tick(8);
        rd(5); chk("reload_fd", rdat, 8'hFD);
        wr(0, 8'h00);
        chk("reg0_clears_irq", irq, 0);

        // Hold direction: prescaler runs, counter frozen
        wr(1, 8'h00);
        tick(8);
        rd(4); chk("hold_pre", rdat, 8'h08);
        rd(5); chk("hold_cnt", rdat, 8'hFD);

        // A12 source with low-time filter
        wr(6, 8'h00);
        wr(4, 8'h00);
        wr(1, 8'h01);
        ppu_a12 = 1'b1; cyc(6);
        rd(4); chk("a12_first_rise", rdat, 8'h01);
        ppu_a12 = 1'b0; cyc(2);
        ppu_a12 = 1'b1; cyc(6);
        rd(4); chk("a12_short_low", rdat, 8'h01);
        ppu_a12 = 1'b0; cyc(5);
        ppu_a12 = 1'b1; cyc(6);
        rd(4); chk("a12_long_low", rdat, 8'h02);
        ppu_a12 = 1'b0;

        // PPU-read source; CPU ticks ignored
        wr(1, 8'h02);
        ppu_rd = 1'b1; cyc(3); ppu_rd = 1'b0;
        rd(4); chk("ppurd_pre", rdat, 8'h05);
        tick(1);
        rd(4); chk("ppurd_ignores_cpu", rdat, 8'h05);

        // Reset in the middle of operation
        wr(1, 8'h80);
        wr(5, 8'h00);
        wr(4, 8'hFF);
        wr(3, 8'h00);
        tick(1);
        chk("pre_rst_irq", irq, 1);
        wr(5, 8'h37);
        wr(6, 8'h11);
        rd(5); chk("pre_rst_cnt", rdat, 8'h37);
        rd(0); chk("pre_rst_pend", rdat, 8'h01);
        map_rst_n = 1'b0;
        cyc(1);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_rdat", rdat, 0);
        map_rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            chk($sformatf("rst_read_%0d", a), rdat, 8'h00);
        end
        tick(3);
        rd(4); chk("rst_pre_restart", rdat, 8'h03);

        // 16-bit counter: 0x100 steps before the terminal step
        map_rst_n = 1'b0;
        cyc(1);
        map_rst_n = 1'b1;
        wr(7, 8'h01);
        wr(5, 8'h00);
        rd(7);
        chk("w16_hi_read", rdat16, 8'h01);
        chk("w8_hi_ignored", rdat, 8'h00);
        rd(5); chk("w16_lo_read", rdat16, 8'h00);
        wr(1, 8'h84);
        wr(3, 8'h00);
        tick(2048);
        chk("w16_irq_256", irq16, 0);
        chk("w8_irq_early", irq, 1);
        rd(7); chk("w16_hi_zero", rdat16, 8'h00);
        rd(5); chk("w16_lo_zero", rdat16, 8'h00);
        tick(8);
        chk("w16_irq_257", irq16, 1);
        rd(7); chk("w16_hi_wrap", rdat16, 8'hFF);
        rd(5); chk("w16_lo_wrap", rdat16, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
